// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: burst-aware, wait-state-frozen grant of one of MASTER_NUM masters.
// Optional DYNAMIC_PRIORITY_ARBITER_EN adds the hprior port and highest-priority-wins selection.
module ahb_slave_arbiter #(
    parameter int unsigned MASTER_NUM = 4,
    parameter int unsigned MASTER_BIT = $clog2(MASTER_NUM),
    parameter int unsigned ARB_MODE   = 1,
    parameter int unsigned PRIOR_BIT  = 2
) (
    input  logic                            hclk,
    input  logic                            hreset_n,
    input  logic [MASTER_NUM-1:0]           hreq,
    input  logic [MASTER_NUM-1:0]           hlast,
    input  logic                            hwait,
`ifdef DYNAMIC_PRIORITY_ARBITER_EN
    input  logic [MASTER_NUM*PRIOR_BIT-1:0] hprior,
`endif
    output logic [MASTER_NUM-1:0]           hgrant,
    output logic                            hsel,
    output logic [MASTER_BIT-1:0]           hmaster
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [MASTER_BIT-1:0]   rr_ptr, rr_ptr_nxt;
    logic [MASTER_NUM-1:0]   grant_nxt;
    logic                    sel_nxt;
    logic [MASTER_BIT-1:0]   master_nxt;

    logic [MASTER_NUM-1:0]   cand;
    logic [MASTER_BIT-1:0]   winner;
    logic [MASTER_BIT-1:0]   rr_sel;
    logic                    found;
    logic                    release_c;
    logic                    do_grant;

    // Candidate set: every requester, or only those sharing the top priority.
`ifdef DYNAMIC_PRIORITY_ARBITER_EN
    logic [PRIOR_BIT-1:0]    max_prior;

    always_comb begin
        max_prior = '0;
        cand      = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (hreq[i] && (hprior[i*PRIOR_BIT +: PRIOR_BIT] > max_prior)) begin
                max_prior = hprior[i*PRIOR_BIT +: PRIOR_BIT];
            end
        end
        for (int i = 0; i < MASTER_NUM; i++) begin
            cand[i] = hreq[i] && (hprior[i*PRIOR_BIT +: PRIOR_BIT] == max_prior);
        end
    end
`else
    always_comb begin
        cand = hreq;
    end
`endif

    // Fixed: lowest index. Round-robin: search upward from last owner + 1, owner itself last.
    always_comb begin
        winner = '0;
        rr_sel = '0;
        found  = 1'b0;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < MASTER_NUM; i++) begin
                if (cand[i] && !found) begin
                    winner = MASTER_BIT'(i);
                    found  = 1'b1;
                end
            end
        end else begin
            for (int unsigned k = 1; k <= MASTER_NUM; k++) begin
                rr_sel = MASTER_BIT'((32'(rr_ptr) + k) % MASTER_NUM);
                if (cand[rr_sel] && !found) begin
                    winner = rr_sel;
                    found  = 1'b1;
                end
            end
        end
    end

    assign release_c = !hwait && (hlast[hmaster] || !hreq[hmaster]);

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state;
        grant_nxt  = hgrant;
        sel_nxt    = hsel;
        master_nxt = hmaster;
        rr_ptr_nxt = rr_ptr;
        do_grant   = 1'b0;

        case (state)
            IDLE: begin
                do_grant = |hreq;
            end
            OWNED: begin
                if (release_c) begin
                    if (|hreq) begin
                        do_grant = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        sel_nxt   = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                sel_nxt   = 1'b0;
            end
        endcase

        if (do_grant) begin
            state_nxt  = OWNED;
            grant_nxt  = MASTER_NUM'(1) << winner;
            sel_nxt    = 1'b1;
            master_nxt = winner;
            rr_ptr_nxt = winner;
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state   <= IDLE;
            hgrant  <= '0;
            hsel    <= 1'b0;
            hmaster <= '0;
            rr_ptr  <= MASTER_BIT'(MASTER_NUM - 1);
        end else begin
            state   <= state_nxt;
            hgrant  <= grant_nxt;
            hsel    <= sel_nxt;
            hmaster <= master_nxt;
            rr_ptr  <= rr_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Bench for ahb_slave_arbiter: round-robin and fixed-priority instances share stimulus,
// expectations come from a hand-derived vector table via a scoreboard queue.
module tb_ahb_slave_arbiter;

    logic       hclk;
    logic       hreset_n;
    logic [3:0] hreq;
    logic [3:0] hlast;
    logic       hwait;
`ifdef DYNAMIC_PRIORITY_ARBITER_EN
    logic [7:0] hprior;
`endif

    logic [3:0] g_rr, g_fx;
    logic       s_rr, s_fx;
    logic [1:0] m_rr, m_fx;

    int total = 0;
    int bad   = 0;

    ahb_slave_arbiter #(.MASTER_NUM(4), .ARB_MODE(1), .PRIOR_BIT(2)) dut_rr (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .hreq     (hreq),
        .hlast    (hlast),
        .hwait    (hwait),
`ifdef DYNAMIC_PRIORITY_ARBITER_EN
        .hprior   (hprior),
`endif
        .hgrant   (g_rr),
        .hsel     (s_rr),
        .hmaster  (m_rr)
    );

    ahb_slave_arbiter #(.MASTER_NUM(4), .ARB_MODE(0), .PRIOR_BIT(2)) dut_fx (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .hreq     (hreq),
        .hlast    (hlast),
        .hwait    (hwait),
`ifdef DYNAMIC_PRIORITY_ARBITER_EN
        .hprior   (hprior),
`endif
        .hgrant   (g_fx),
        .hsel     (s_fx),
        .hmaster  (m_fx)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] last;
        logic       hw;
        logic [7:0] prior;
        logic [3:0] g_rr;
        logic [1:0] m_rr;
        logic [3:0] g_fx;
        logic [1:0] m_fx;
    } vec_t;

    typedef struct {
        logic [3:0] g_rr;
        logic [1:0] m_rr;
        logic [3:0] g_fx;
        logic [1:0] m_fx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Grant must be one-hot or zero and hsel must track it on every cycle.
    always @(negedge hclk) begin
        total++;
        if (!$onehot0(g_rr) || !$onehot0(g_fx) || (s_rr !== |g_rr) || (s_fx !== |g_fx)) begin
            bad++;
            $display("FAIL onehot: rr=%b/%b fx=%b/%b", g_rr, s_rr, g_fx, s_fx);
        end
    end

    task automatic apply(input vec_t v, input int n);
        exp_t e;
        @(negedge hclk);
        hreq  = v.req;
        hlast = v.last;
        hwait = v.hw;
`ifdef DYNAMIC_PRIORITY_ARBITER_EN
        hprior = v.prior;
`endif
        sb.push_back('{v.g_rr, v.m_rr, v.g_fx, v.m_fx});
        @(posedge hclk);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("v%0d_sb_empty", n), 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d_grant_rr", n), 32'(g_rr), 32'(e.g_rr));
            chk($sformatf("v%0d_master_rr", n), 32'(m_rr), 32'(e.m_rr));
            chk($sformatf("v%0d_sel_rr", n), 32'(s_rr), 32'(|e.g_rr));
            chk($sformatf("v%0d_grant_fx", n), 32'(g_fx), 32'(e.g_fx));
            chk($sformatf("v%0d_master_fx", n), 32'(m_fx), 32'(e.m_fx));
            chk($sformatf("v%0d_sel_fx", n), 32'(s_fx), 32'(|e.g_fx));
        end
    endtask

    initial begin
        // {req, last, wait, prior, grant_rr, master_rr, grant_fx, master_fx}
        vecs.push_back('{4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 2'd0, 4'b0000, 2'd0});
        vecs.push_back('{4'b0100, 4'b0000, 1'b0, 8'h00, 4'b0100, 2'd2, 4'b0100, 2'd2});
        vecs.push_back('{4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 2'd2, 4'b0000, 2'd2});
        vecs.push_back('{4'b0010, 4'b0000, 1'b0, 8'h00, 4'b0010, 2'd1, 4'b0010, 2'd1});
        vecs.push_back('{4'b1111, 4'b0010, 1'b1, 8'h00, 4'b0010, 2'd1, 4'b0010, 2'd1});
        vecs.push_back('{4'b1111, 4'b0010, 1'b1, 8'h00, 4'b0010, 2'd1, 4'b0010, 2'd1});
        vecs.push_back('{4'b1111, 4'b0010, 1'b1, 8'h00, 4'b0010, 2'd1, 4'b0010, 2'd1});
        vecs.push_back('{4'b1111, 4'b0010, 1'b0, 8'h00, 4'b0100, 2'd2, 4'b0001, 2'd0});
        vecs.push_back('{4'b1111, 4'b1111, 1'b0, 8'h00, 4'b1000, 2'd3, 4'b0001, 2'd0});
        vecs.push_back('{4'b1111, 4'b1111, 1'b0, 8'h00, 4'b0001, 2'd0, 4'b0001, 2'd0});
        vecs.push_back('{4'b1111, 4'b1111, 1'b0, 8'h00, 4'b0010, 2'd1, 4'b0001, 2'd0});
        vecs.push_back('{4'b1111, 4'b1111, 1'b0, 8'h00, 4'b0100, 2'd2, 4'b0001, 2'd0});
        vecs.push_back('{4'b1111, 4'b1111, 1'b0, 8'h00, 4'b1000, 2'd3, 4'b0001, 2'd0});
        vecs.push_back('{4'b1111, 4'b1111, 1'b0, 8'h00, 4'b0001, 2'd0, 4'b0001, 2'd0});
        vecs.push_back('{4'b1111, 4'b1110, 1'b0, 8'h00, 4'b0001, 2'd0, 4'b0001, 2'd0});
        vecs.push_back('{4'b1110, 4'b0000, 1'b1, 8'h00, 4'b0001, 2'd0, 4'b0001, 2'd0});
        vecs.push_back('{4'b1110, 4'b0000, 1'b0, 8'h00, 4'b0010, 2'd1, 4'b0010, 2'd1});
        vecs.push_back('{4'b1000, 4'b0010, 1'b0, 8'h00, 4'b1000, 2'd3, 4'b1000, 2'd3});
        vecs.push_back('{4'b1001, 4'b1000, 1'b0, 8'h00, 4'b0001, 2'd0, 4'b0001, 2'd0});
        vecs.push_back('{4'b0001, 4'b0001, 1'b0, 8'h00, 4'b0001, 2'd0, 4'b0001, 2'd0});
        vecs.push_back('{4'b0001, 4'b0001, 1'b0, 8'h00, 4'b0001, 2'd0, 4'b0001, 2'd0});
        vecs.push_back('{4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 2'd0, 4'b0000, 2'd0});
        vecs.push_back('{4'b1010, 4'b0000, 1'b0, 8'h00, 4'b0010, 2'd1, 4'b0010, 2'd1});
        vecs.push_back('{4'b1010, 4'b0000, 1'b0, 8'h00, 4'b0010, 2'd1, 4'b0010, 2'd1});
        vecs.push_back('{4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 2'd1, 4'b0000, 2'd1});
        vecs.push_back('{4'b1000, 4'b0000, 1'b1, 8'h00, 4'b1000, 2'd3, 4'b1000, 2'd3});
        vecs.push_back('{4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 2'd3, 4'b0000, 2'd3});
`ifdef DYNAMIC_PRIORITY_ARBITER_EN
        // Priority winner, then a 1/2 tie split by each instance's own policy.
        vecs.push_back('{4'b0110, 4'b0000, 1'b0, 8'h1C, 4'b0010, 2'd1, 4'b0010, 2'd1});
        vecs.push_back('{4'b0000, 4'b0000, 1'b0, 8'h1C, 4'b0000, 2'd1, 4'b0000, 2'd1});
        vecs.push_back('{4'b0110, 4'b0000, 1'b0, 8'h28, 4'b0100, 2'd2, 4'b0010, 2'd1});
`endif

        hreset_n = 1'b0;
        hreq     = '0;
        hlast    = '0;
        hwait    = 1'b0;
`ifdef DYNAMIC_PRIORITY_ARBITER_EN
        hprior   = '0;
`endif
        repeat (2) @(posedge hclk);
        #1;
        chk("reset_grant", 32'({g_rr, g_fx}), 32'd0);
        chk("reset_sel", 32'({s_rr, s_fx}), 32'd0);
        chk("reset_master", 32'({m_rr, m_fx}), 32'd0);
        @(negedge hclk);
        hreset_n = 1'b1;

        // Ten idle cycles with no requests.
        for (int c = 0; c < 10; c++) begin
            @(posedge hclk);
            #1;
            chk($sformatf("idle%0d", c), 32'({g_rr, s_rr, m_rr, g_fx, s_fx, m_fx}), 32'd0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Asynchronous reset in the middle of an owned burst.
        @(negedge hclk);
        hreq  = 4'b0001;
        hlast = 4'b0000;
        hwait = 1'b0;
        @(posedge hclk);
        #1;
        chk("preburst_rr", 32'(g_rr), 32'h1);
        chk("preburst_fx", 32'(g_fx), 32'h1);
        #2;
        hreset_n = 1'b0;
        #1;
        chk("async_rst_grant", 32'({g_rr, g_fx}), 32'd0);
        chk("async_rst_sel", 32'({s_rr, s_fx}), 32'd0);
        chk("async_rst_master", 32'({m_rr, m_fx}), 32'd0);

        // Pointer restarts at master 0 after reset.
        @(negedge hclk);
        hreset_n = 1'b1;
        hreq     = 4'b1110;
`ifdef DYNAMIC_PRIORITY_ARBITER_EN
        hprior   = '0;
`endif
        @(posedge hclk);
        #1;
        chk("post_rst_rr", 32'({g_rr, m_rr}), 32'({4'b0010, 2'd1}));
        chk("post_rst_fx", 32'({g_fx, m_fx}), 32'({4'b0010, 2'd1}));

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_slave_arbiter.md
Name: ahb_slave_arbiter

Overview:
- Per-slave AHB bus arbiter: selects one of MASTER_NUM requesting masters for a single slave port in the multi-layer interconnect.
- Instantiated once per slave, between the master-side decoders (which produce hreq/hlast) and the slave mux (which consumes hgrant/hmaster).
- Generalises the earlier fixed-width arbiter interface to:
  - a parametrised master count;
  - selectable fixed/round-robin policy;
  - burst-aware hold, wait-state-aware handover and back-to-back regrant;
  - optional dynamic priority.

Parameters:
- MASTER_NUM, 4, number of requesting masters (2..16).
- MASTER_BIT, $clog2(MASTER_NUM), width of hmaster.
- ARB_MODE, 1, 0 = fixed priority (lowest index wins); 1 = round-robin.
- PRIOR_BIT, 2, width of each dynamic priority field (used only with the optional feature).

Ports:
- hclk  input  1  bus clock; all state updates on rising edge.
- hreset_n  input  1  asynchronous active-low reset.
- hreq  input  MASTER_NUM  per-master request to this slave, from the master-side decoders.
- hlast  input  MASTER_NUM  per-master "final beat of current burst/transfer" flag.
- hwait  input  1  1 = slave inserting wait state (inverted HREADY); arbitration is frozen while high.
- hgrant  output  MASTER_NUM  registered one-hot grant; all zero when no owner.
- hsel  output  1  registered; 1 while any master owns the slave.
- hmaster  output  MASTER_BIT  registered index of current/last owner; drives the slave-side mux.
- hprior  input  MASTER_NUM*PRIOR_BIT  per-master priority, master i at [i*PRIOR_BIT +: PRIOR_BIT]. Present only with DYNAMIC_PRIORITY_ARBITER_EN.

Behaviour:
- Clock and reset: one clock (hclk); reset hreset_n is asynchronous, active-low.
- Reset values:
  - hgrant = 0, hsel = 0, hmaster = 0, state = IDLE.
  - Round-robin last-owner pointer = MASTER_NUM-1, so master 0 is first in round-robin order.
  - Reset asserted mid-burst clears everything immediately, with no wait for the clock.
- States: IDLE and OWNED.
- IDLE:
  - If any hreq bit is set, the winner is chosen combinationally. On the next edge: hgrant = onehot(winner), hmaster = winner, hsel = 1, state -> OWNED.
  - Latency is exactly 1 cycle from hreq sampled to hgrant visible.
  - hwait is ignored in IDLE.
- OWNED:
  - hgrant/hsel/hmaster hold while hwait = 1, regardless of hreq/hlast changes.
  - Release condition, evaluated only when hwait = 0: hlast[hmaster] = 1 OR hreq[hmaster] = 0.
  - On release with at least one hreq bit set: regrant on the same edge with no idle gap. The new one-hot grant appears next cycle and the state stays OWNED.
  - On release with no requests: state -> IDLE, hgrant = 0, hsel = 0, and hmaster keeps the last owner (bus parking).
  - No release: grant unchanged, even if a higher-priority master requests. Bursts are never pre-empted.
- Winner selection:
  - ARB_MODE = 0: lowest-index asserted hreq.
  - ARB_MODE = 1: search from (last owner + 1) modulo MASTER_NUM upward with wrap. The releasing owner is considered last, so it is regranted only if it is the sole requester.
  - The round-robin pointer updates only when a grant is issued.
- hgrant is always one-hot or zero; this must never be violated (assertion in bench).
- hlast or hreq on a non-owner bit has no effect while OWNED.

Optional Feature:
- Macro: DYNAMIC_PRIORITY_ARBITER_EN.
- Defined:
  - The hprior port exists.
  - The winner is the requesting master with the numerically highest hprior field.
  - Ties are broken by the ARB_MODE rule restricted to the tied masters.
  - hprior is sampled in the same cycle as the arbitration decision and is never registered.
- Undefined: the port is absent and selection is purely by ARB_MODE.

Test Plan:
- Reset then idle: hreq = 0 for 10 cycles -> hgrant = 0, hsel = 0, hmaster = 0 throughout; assert hreset_n low mid-burst -> outputs zero without a clock edge.
- Single request, ARB_MODE = 1: hreq = 4'b0100 at cycle 0 -> hgrant = 4'b0100, hmaster = 2, hsel = 1 at cycle 1; hreq = 0 with hwait = 0 -> hgrant = 0, hsel = 0, hmaster stays 2.
- Burst hold under wait states:
  - Setup: master 1 owns; hreq = 4'b1111; hlast[1] = 1 with hwait = 1 for 3 cycles -> grant stays 4'b0010.
  - Then hwait = 0 -> next cycle hgrant = 4'b0100 (round-robin next after 1).
- Round-robin fairness: hreq = 4'b1111 constant, hlast pulsed with hwait = 0 on every owned cycle -> grant order 0, 1, 2, 3, 0 with no gap cycles; ARB_MODE = 0 same stimulus -> master 0 regranted every time.
- Wrap and owner-last:
  - Master 3 owns; hreq = 4'b1001 with release -> hgrant = 4'b0001.
  - Then only master 0 requests and releases -> master 0 regranted back-to-back.
- With DYNAMIC_PRIORITY_ARBITER_EN, hreq = 4'b0110, hprior = {2'd0, 2'd1, 2'd3, 2'd0} (master 3..0) -> grant 4'b0010.
  - Then set masters 1 and 2 to an equal value -> tie resolved by ARB_MODE.
